// File: rtl/seg7_pkg.sv
// Shared BCD digit type, digit limits and load-value clamp for the 7-segment counter.
// Pure declarations: no latency, no flow control.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

    function automatic bcd_t bcd_clamp(bcd_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_counter_4dig_if.sv
// Control and display bundle of the four-digit BCD counter.
// master drives run/direction/load, slave (the counter) drives digits, pulses and blank flags.
interface bcd_counter_4dig_if;
    import seg7_pkg::*;

    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    bcd_t        qn1;
    bcd_t        qn2;
    bcd_t        qn3;
    bcd_t        qn4;
    logic        tick_o;
    logic        tc;
    logic [3:0]  blank;

    modport master (
        output en, up, load, load_val,
        input  qn1, qn2, qn3, qn4, tick_o, tc, blank
    );

    modport slave (
        input  en, up, load, load_val,
        output qn1, qn2, qn3, qn4, tick_o, tc, blank
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain: load (clamped) beats step; wrap flags 9 (up) or 0 (down).
// Latency: digit updates on the edge after step/load; wrap is combinational. No backpressure.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic up,
    input  logic load,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic wrap
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = bcd_clamp(ld_val);
        end else if (step) begin
            if (up) begin
                q_d = (q_q == BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
            end else begin
                q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign wrap = up ? (q_q == BCD_MAX) : (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_4dig.sv
// Four-digit BCD up/down counter stepped by an internal TICK_DIV prescaler; optional blanking via LEADING_ZERO_BLANK_EN.
// Latency: digits, tick_o and tc change together on the step edge. No backpressure; load overrides a step.
module bcd_counter_4dig
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_counter_4dig_if.slave  bus
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          step_evt;
    logic          step;
    logic [3:0]    dig_step;
    logic [3:0]    wrap;
    bcd_t          q [4];
    logic          tick_q;
    logic          tc_q;

    assign step_evt = bus.en && (presc_q == PRESC_LAST);
    assign step     = step_evt && !bus.load;

    always_comb begin
        presc_d = presc_q;
        if (bus.load || step_evt) begin
            presc_d = '0;
        end else if (bus.en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Ripple enable: a digit steps only when every lower digit is at its wrap value.
    always_comb begin
        dig_step    = '0;
        dig_step[0] = step;
        dig_step[1] = step && wrap[0];
        dig_step[2] = step && (&wrap[1:0]);
        dig_step[3] = step && (&wrap[2:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= step;
            tc_q    <= step && (&wrap);
        end
    end

    for (genvar k = 0; k < 4; k++) begin : gen_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .step   (dig_step[k]),
            .up     (bus.up),
            .load   (bus.load),
            .ld_val (bus.load_val[4*k +: 4]),
            .q      (q[k]),
            .wrap   (wrap[k])
        );
    end

    assign bus.qn1    = q[0];
    assign bus.qn2    = q[1];
    assign bus.qn3    = q[2];
    assign bus.qn4    = q[3];
    assign bus.tick_o = tick_q;
    assign bus.tc     = tc_q;

`ifdef LEADING_ZERO_BLANK_EN
    // Decoded straight from the digit flops, so blank changes on the same edge as the digits.
    assign bus.blank = {(q[3] == BCD_ZERO),
                        (q[3] == BCD_ZERO) && (q[2] == BCD_ZERO),
                        (q[3] == BCD_ZERO) && (q[2] == BCD_ZERO) && (q[1] == BCD_ZERO),
                        1'b0};
`else
    assign bus.blank = 4'b0000;
`endif

endmodule
